sp1_ram_master: RTL and testbench



---
 rtl/sp1_ram_master_pkg.sv | 25 ++
 rtl/sp1_ram_master.sv | 115 +++++++++++
 tb/tb_sp1_ram_master.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sp1_ram_master_pkg.sv
// sp1_ram_master_pkg: shared constants and types for the sp1_ram initiator.
//   ADR_W_DEF / DAT_W_DEF : default RAM address / data widths
//   LEN_W                 : width of the burst-length request field
//   BURST_MAX             : burst length encoded by req_len == 0
//   sp1_rm_state_e        : initiator FSM state encoding
//   burst_words()         : decodes req_len into a word count (1..8)
package sp1_ram_master_pkg;

    localparam int ADR_W_DEF = 6;
    localparam int DAT_W_DEF = 32;
    localparam int LEN_W     = 3;
    localparam int BURST_MAX = 8;

    typedef enum logic [1:0] {
        SP1_RM_IDLE  = 2'd0,
        SP1_RM_WRITE = 2'd1,
        SP1_RM_READ  = 2'd2
    } sp1_rm_state_e;

    // A zero length field stands for the longest burst.
    function automatic logic [LEN_W:0] burst_words(input logic [LEN_W-1:0] len);
        return (len == '0) ? (LEN_W+1)'(BURST_MAX) : {1'b0, len};
    endfunction

endpackage

// File: rtl/sp1_ram_master.sv
// sp1_ram_master: valid/ready front end that turns word-write and burst-read
// requests into sp1_ram pin activity.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake
//   req_we                : 1 = single-word write, 0 = burst read
//   req_adr/req_len       : start address / burst length (0 = 8 words)
//   req_wdata             : write data
//   wr_done               : one-cycle pulse after the RAM write cycle
//   rd_valid/rd_data/rd_last : read word stream, no back-pressure
//   ram_cs/ram_we/ram_adr/ram_din : registered RAM controls
//   ram_dout              : RAM read data (valid the cycle after sampling)
module sp1_ram_master
    import sp1_ram_master_pkg::*;
#(
    parameter int ADR_W = ADR_W_DEF,
    parameter int DAT_W = DAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [ADR_W-1:0] req_adr,
    input  logic [LEN_W-1:0] req_len,
    input  logic [DAT_W-1:0] req_wdata,
    output logic             wr_done,
    output logic             rd_valid,
    output logic [DAT_W-1:0] rd_data,
    output logic             rd_last,
    output logic             ram_cs,
    output logic             ram_we,
    output logic [ADR_W-1:0] ram_adr,
    output logic [DAT_W-1:0] ram_din,
    input  logic [DAT_W-1:0] ram_dout
);

    sp1_rm_state_e    state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;      // reads still to issue after the current one
    logic             cs_d, we_d;
    logic [ADR_W-1:0] adr_d;
    logic [DAT_W-1:0] din_d;
    logic             rd_valid_d, rd_last_d, wr_done_d;

    assign req_ready = (state_q == SP1_RM_IDLE) && !rst;
    assign rd_data   = ram_dout;

    // The RAM pins are loaded on the accepting edge, so the first issue is
    // already on the pins during the first WRITE/READ cycle; the pin
    // registers double as the latched address and data.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cs_d    = 1'b0;
        we_d    = 1'b0;
        adr_d   = ram_adr;
        din_d   = ram_din;
        case (state_q)
            SP1_RM_IDLE: begin
                if (req_valid && req_ready) begin
                    cs_d  = 1'b1;
                    adr_d = req_adr;
                    if (req_we) begin
                        we_d    = 1'b1;
                        din_d   = req_wdata;
                        state_d = SP1_RM_WRITE;
                    end else begin
                        cnt_d   = LEN_W'(burst_words(req_len) - 1'b1);
                        state_d = SP1_RM_READ;
                    end
                end
            end
            SP1_RM_WRITE: state_d = SP1_RM_IDLE;
            SP1_RM_READ: begin
                if (cnt_q == '0) begin
                    state_d = SP1_RM_IDLE;
                end else begin
                    cs_d  = 1'b1;
                    adr_d = ram_adr + ADR_W'(1);   // wraps modulo 2^ADR_W
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = SP1_RM_IDLE;
        endcase

        // Data returns one cycle after the RAM samples a read.
        rd_valid_d = ram_cs && !ram_we;
        rd_last_d  = rd_valid_d && (state_q == SP1_RM_READ) && (cnt_q == '0);
        wr_done_d  = (state_q == SP1_RM_WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SP1_RM_IDLE;
            cnt_q    <= '0;
            ram_cs   <= 1'b0;
            ram_we   <= 1'b0;
            ram_adr  <= '0;
            ram_din  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            wr_done  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ram_cs   <= cs_d;
            ram_we   <= we_d;
            ram_adr  <= adr_d;
            ram_din  <= din_d;
            rd_valid <= rd_valid_d;
            rd_last  <= rd_last_d;
            wr_done  <= wr_done_d;
        end
    end

endmodule

// File: tb/tb_sp1_ram_master.sv
// tb_sp1_ram_master: bench for sp1_ram_master with a behavioural sp1_ram,
// a shadow memory plus expected-word queue as reference, and directed and
// random request sequences.
module tb_sp1_ram_master;

    localparam int ADR_W = 6;
    localparam int DAT_W = 32;
    localparam int DEPTH = 1 << ADR_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_we = 1'b0;
    logic [ADR_W-1:0] req_adr = '0;
    logic [2:0]       req_len = '0;
    logic [DAT_W-1:0] req_wdata = '0;
    logic             wr_done, rd_valid, rd_last;
    logic [DAT_W-1:0] rd_data;
    logic             ram_cs, ram_we;
    logic [ADR_W-1:0] ram_adr;
    logic [DAT_W-1:0] ram_din;
    logic [DAT_W-1:0] ram_dout = '0;

    always #5 clk = ~clk;

    sp1_ram_master #(.ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_adr(req_adr), .req_len(req_len), .req_wdata(req_wdata),
        .wr_done(wr_done), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    // Behavioural sp1_ram: synchronous write, registered read.
    logic [DAT_W-1:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ram_cs && ram_we)  mem[ram_adr] <= ram_din;
        if (ram_cs && !ram_we) ram_dout <= mem[ram_adr];
    end

    // Reference: what memory should hold and which words should come back.
    typedef struct { logic [DAT_W-1:0] data; logic last; } exp_t;
    logic [DAT_W-1:0] ref_mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    exp_t exp_q[$];
    exp_t mon_e;

    int n_cmp = 0, n_err = 0;
    int rd_seen = 0, wr_seen = 0;

    // Read-stream monitor: every rd_valid word must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_valid) begin
                rd_seen++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_unexpected: rd_valid=1 data=%h, required no word", rd_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (rd_data !== mon_e.data || rd_last !== mon_e.last) begin
                        n_err++;
                        $display("FAIL rd_word: got data=%h last=%b, required data=%h last=%b",
                                 rd_data, rd_last, mon_e.data, mon_e.last);
                    end
                end
            end
            if (wr_done) wr_seen++;
        end
    end

    // Present one request, wait (bounded) for acceptance, update the model.
    task automatic issue(input logic we, input logic [ADR_W-1:0] adr, input logic [2:0] len,
                         input logic [DAT_W-1:0] wd, output int stalls);
        bit ok = 0;
        int words;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_adr = adr; req_len = len; req_wdata = wd;
        stalls = 0;
        for (int n = 0; n < 60; n++) begin
            if (req_ready) begin ok = 1; break; end
            stalls++;
            @(negedge clk);
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL handshake_timeout: req_ready=%b, required 1 within 60 cycles", req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (we) begin
            ref_mem[adr] = wd;
        end else begin
            words = (len == 0) ? 8 : int'(len);
            for (int i = 0; i < words; i++)
                exp_q.push_back('{ref_mem[(int'(adr) + i) % DEPTH], i == words - 1});
        end
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && req_ready) begin ok = 1; break; end
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({ram_cs, ram_we, ram_adr, ram_din, rd_valid, rd_last, wr_done, req_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: cs=%b we=%b adr=%h din=%h rv=%b rl=%b wd=%b rdy=%b, required all 0",
                     ram_cs, ram_we, ram_adr, ram_din, rd_valid, rd_last, wr_done, req_ready);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || ram_cs !== 1'b0 || rd_valid !== 1'b0 || wr_done !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: rdy=%b cs=%b rv=%b wd=%b, required rdy=1 others 0",
                     req_ready, ram_cs, rd_valid, wr_done);
        end
    endtask

    task automatic test_write_read1();
        int st, w0;
        w0 = wr_seen;
        issue(1'b1, 6'h20, 3'd0, 32'hdeadbeef, st);
        @(negedge clk);
        n_cmp++;
        if (ram_cs !== 1 || ram_we !== 1 || ram_adr !== 6'h20 || ram_din !== 32'hdeadbeef || req_ready !== 0) begin
            n_err++;
            $display("FAIL write_pins: cs=%b we=%b adr=%h din=%h rdy=%b, required 1 1 20 deadbeef 0",
                     ram_cs, ram_we, ram_adr, ram_din, req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (wr_done !== 1 || ram_cs !== 0 || req_ready !== 1) begin
            n_err++;
            $display("FAIL write_done: wr_done=%b cs=%b rdy=%b, required 1 0 1", wr_done, ram_cs, req_ready);
        end
        issue(1'b0, 6'h20, 3'd1, '0, st);
        @(negedge clk);
        n_cmp++;
        if (ram_cs !== 1 || ram_we !== 0 || ram_adr !== 6'h20 || rd_valid !== 0) begin
            n_err++;
            $display("FAIL read1_issue: cs=%b we=%b adr=%h rv=%b, required 1 0 20 0",
                     ram_cs, ram_we, ram_adr, rd_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (rd_valid !== 1 || rd_data !== 32'hdeadbeef || rd_last !== 1 || req_ready !== 1) begin
            n_err++;
            $display("FAIL read1_data: rv=%b data=%h last=%b rdy=%b, required 1 deadbeef 1 1",
                     rd_valid, rd_data, rd_last, req_ready);
        end
        drain();
        n_cmp++;
        if (wr_seen - w0 !== 1) begin
            n_err++;
            $display("FAIL write_done_count: %0d pulses, required 1", wr_seen - w0);
        end
    endtask

    task automatic test_wrap();
        int st;
        logic [ADR_W-1:0] base = 6'h3e;
        logic [ADR_W-1:0] want;
        for (int i = 0; i < 4; i++)
            issue(1'b1, base + ADR_W'(i), 3'd0, 32'h11111111 * (i + 1), st);
        issue(1'b0, base, 3'd4, '0, st);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            want = base + ADR_W'(i);
            n_cmp++;
            if (ram_cs !== 1 || ram_we !== 0 || ram_adr !== want) begin
                n_err++;
                $display("FAIL wrap_adr%0d: cs=%b we=%b adr=%h, required 1 0 %h", i, ram_cs, ram_we, ram_adr, want);
            end
        end
        drain();
    endtask

    task automatic test_len8();
        int st, r0, lows = 0;
        r0 = rd_seen;
        issue(1'b0, 6'h08, 3'd0, '0, st);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (!req_ready) lows++;
            else break;
        end
        n_cmp++;
        if (lows !== 8) begin
            n_err++;
            $display("FAIL len8_busy: req_ready low %0d cycles, required 8", lows);
        end
        drain();
        n_cmp++;
        if (rd_seen - r0 !== 8) begin
            n_err++;
            $display("FAIL len8_words: %0d words, required 8", rd_seen - r0);
        end
    endtask

    task automatic test_stall();
        int st, w0;
        w0 = wr_seen;
        issue(1'b0, 6'h10, 3'd4, '0, st);
        issue(1'b1, 6'h30, 3'd0, 32'hcafef00d, st);
        n_cmp++;
        if (st !== 4) begin
            n_err++;
            $display("FAIL stall_cycles: stalled %0d, required 4", st);
        end
        issue(1'b0, 6'h30, 3'd1, '0, st);
        drain();
        n_cmp++;
        if (wr_seen - w0 !== 1) begin
            n_err++;
            $display("FAIL stall_wr_done: %0d pulses, required 1", wr_seen - w0);
        end
    endtask

    task automatic test_reset_mid_burst();
        int st, r0;
        bit ok = 0;
        r0 = rd_seen;
        issue(1'b0, 6'h3c, 3'd0, '0, st);
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (rd_seen - r0 >= 2) begin ok = 1; break; end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL midrst_wait: %0d words, required 2", rd_seen - r0);
        end
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        // first cycle after the reset edge
        n_cmp++;
        if (rd_valid !== 0 || ram_cs !== 0 || rd_last !== 0) begin
            n_err++;
            $display("FAIL midrst_outputs: rv=%b cs=%b rl=%b, required 0 0 0", rd_valid, ram_cs, rd_last);
        end
        r0 = rd_seen;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (rd_seen - r0 !== 0) begin
            n_err++;
            $display("FAIL midrst_extra: %0d words after reset, required 0", rd_seen - r0);
        end
        issue(1'b0, 6'h3e, 3'd4, '0, st);
        drain();
    endtask

    task automatic test_random();
        int st, r0, words = 0;
        logic we;
        logic [2:0] len;
        r0 = rd_seen;
        for (int i = 0; i < 40; i++) begin
            we  = 1'($urandom_range(0, 1));
            len = 3'($urandom_range(0, 7));
            if (!we) words += (len == 0) ? 8 : int'(len);
            issue(we, ADR_W'($urandom_range(0, DEPTH - 1)), len, $urandom, st);
        end
        drain();
        n_cmp++;
        if (rd_seen - r0 !== words) begin
            n_err++;
            $display("FAIL random_words: %0d words, required %0d", rd_seen - r0, words);
        end
    endtask

    initial begin
        test_reset();
        test_write_read1();
        test_wrap();
        test_len8();
        test_stall();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
